// File: rtl/audio_pkg.sv
// Shared audio-path types and defaults used by the frame buffer, the
// processing top and the downstream stages.
package audio_pkg;

   localparam int DEF_SAMPLE_SIZE = 16;
   localparam int DEF_BUFF_SIZE   = 16;

   typedef logic signed [DEF_SAMPLE_SIZE-1:0] sample_t;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      PUB   = 2'd1,
      STALL = 2'd2
   } fb_state_t;

endpackage

// File: rtl/frame_bank.sv
// One BUFF_SIZE x SAMPLE_SIZE register bank: indexed write, synchronous
// clear, whole contents exposed as a flat packed vector.
module frame_bank #(
   parameter int BUFF_SIZE   = audio_pkg::DEF_BUFF_SIZE,
   parameter int SAMPLE_SIZE = audio_pkg::DEF_SAMPLE_SIZE,
   parameter int PTR_W       = $clog2(BUFF_SIZE)
) (
   input  logic                             clock,
   input  logic                             clear,
   input  logic                             we,
   input  logic [PTR_W-1:0]                 idx,
   input  logic [SAMPLE_SIZE-1:0]           data,
   output logic [BUFF_SIZE*SAMPLE_SIZE-1:0] bank_out
);

   logic [BUFF_SIZE*SAMPLE_SIZE-1:0] mem_d, mem_q;

   always_comb begin
      mem_d = mem_q;
      for (int k = 0; k < BUFF_SIZE; k++) begin
         if (we && (idx == PTR_W'(k))) begin
            mem_d[k*SAMPLE_SIZE +: SAMPLE_SIZE] = data;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         mem_q <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign bank_out = mem_q;

endmodule

// File: rtl/sample_frame_buffer.sv
// Ping-pong frame collector: fills one bank from the sample stream while the
// other bank is published to the processing stage with a valid/done handshake.
module sample_frame_buffer #(
   parameter int BUFF_SIZE   = audio_pkg::DEF_BUFF_SIZE,
   parameter int SAMPLE_SIZE = audio_pkg::DEF_SAMPLE_SIZE,
   parameter int OVR_CNT_W   = 8
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [SAMPLE_SIZE-1:0]           sample_in,
   input  logic                             sample_valid,
   output logic [BUFF_SIZE*SAMPLE_SIZE-1:0] frame_out,
   output logic                             frame_valid,
   input  logic                             proc_done,
   output logic                             overrun,
   output logic [OVR_CNT_W-1:0]             overrun_count
);

   import audio_pkg::*;

   localparam int PTR_W = $clog2(BUFF_SIZE);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(BUFF_SIZE - 1);

   fb_state_t            state_d, state_q;
   logic [PTR_W-1:0]     ptr_d, ptr_q;
   logic                 fill_bank_d, fill_bank_q;
   logic                 overrun_d, overrun_q;
   logic [OVR_CNT_W-1:0] ovr_cnt_d, ovr_cnt_q;

   logic accept, complete, swap;
   logic [BUFF_SIZE*SAMPLE_SIZE-1:0] bank0_out, bank1_out;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      swap        = 1'b0;
      accept      = sample_valid && (state_q != STALL);
      complete    = accept && (ptr_q == LAST_IDX);

      if (accept) begin
         ptr_d = complete ? '0 : ptr_q + 1'b1;
      end

      unique case (state_q)
         FILL: begin
            if (complete) begin
               state_d = PUB;
               swap    = 1'b1;
            end
         end
         PUB: begin
            if (complete && proc_done) begin
               swap = 1'b1;
            end else if (complete) begin
               state_d = STALL;
            end else if (proc_done) begin
               state_d = FILL;
            end
         end
         STALL: begin
            // Any sample arriving alongside proc_done is still dropped.
            if (proc_done) begin
               state_d = PUB;
               swap    = 1'b1;
            end
         end
         default: state_d = FILL;
      endcase

      fill_bank_d = swap ? ~fill_bank_q : fill_bank_q;

      overrun_d = (state_q == STALL) && sample_valid;
      ovr_cnt_d = ovr_cnt_q;
      if (overrun_d && (ovr_cnt_q != '1)) begin
         ovr_cnt_d = ovr_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= FILL;
         ptr_q       <= '0;
         fill_bank_q <= 1'b0;
         overrun_q   <= 1'b0;
         ovr_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         fill_bank_q <= fill_bank_d;
         overrun_q   <= overrun_d;
         ovr_cnt_q   <= ovr_cnt_d;
      end
   end

   frame_bank #(
      .BUFF_SIZE  (BUFF_SIZE),
      .SAMPLE_SIZE(SAMPLE_SIZE),
      .PTR_W      (PTR_W)
   ) u_bank0 (
      .clock   (clock),
      .clear   (reset),
      .we      (accept && !fill_bank_q),
      .idx     (ptr_q),
      .data    (sample_in),
      .bank_out(bank0_out)
   );

   frame_bank #(
      .BUFF_SIZE  (BUFF_SIZE),
      .SAMPLE_SIZE(SAMPLE_SIZE),
      .PTR_W      (PTR_W)
   ) u_bank1 (
      .clock   (clock),
      .clear   (reset),
      .we      (accept && fill_bank_q),
      .idx     (ptr_q),
      .data    (sample_in),
      .bank_out(bank1_out)
   );

   // The published bank is always the one not being filled.
   assign frame_out     = fill_bank_q ? bank0_out : bank1_out;
   assign frame_valid   = (state_q != FILL);
   assign overrun       = overrun_q;
   assign overrun_count = ovr_cnt_q;

endmodule

// File: tb/tb_sample_frame_buffer.sv
// Directed vector bench for sample_frame_buffer with a 4-sample frame.
module tb_sample_frame_buffer;

   localparam int BS = 4;
   localparam int SS = 16;
   localparam int CW = 8;

   localparam logic [63:0] F0 = 64'h0;
   localparam logic [63:0] F1 = 64'hFFFC_0003_FFFE_0001;
   localparam logic [63:0] F2 = 64'h0008_0007_0006_0005;
   localparam logic [63:0] F3 = 64'h000D_000C_000B_000A;
   localparam logic [63:0] F4 = 64'h0017_0016_0015_0014;
   localparam logic [63:0] F5 = 64'h002B_002A_0029_0028;

   typedef struct {
      logic          rst;
      logic          sv;
      logic [SS-1:0] smp;
      logic          pd;
      logic          fv;
      logic          ov;
      logic [CW-1:0] cnt;
      logic [63:0]   frame;
   } vec_t;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic [SS-1:0]    sample_in = '0;
   logic             sample_valid = 1'b0;
   logic             proc_done = 1'b0;
   logic [BS*SS-1:0] frame_out;
   logic             frame_valid;
   logic             overrun;
   logic [CW-1:0]    overrun_count;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_err = 0;

   sample_frame_buffer #(
      .BUFF_SIZE  (BS),
      .SAMPLE_SIZE(SS),
      .OVR_CNT_W  (CW)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .frame_out    (frame_out),
      .frame_valid  (frame_valid),
      .proc_done    (proc_done),
      .overrun      (overrun),
      .overrun_count(overrun_count)
   );

   always #5 clock = ~clock;

   task automatic add(input logic rst, input logic sv, input int smp, input logic pd,
                      input logic fv, input logic ov, input int cnt, input logic [63:0] frame);
      vec_t v;
      v.rst = rst; v.sv = sv; v.smp = SS'(smp); v.pd = pd;
      v.fv = fv; v.ov = ov; v.cnt = CW'(cnt); v.frame = frame;
      vecs.push_back(v);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic fv, input logic ov,
                        input logic [CW-1:0] cnt, input logic [63:0] frame);
      n_vec++;
      if (frame_valid !== fv || overrun !== ov || overrun_count !== cnt || frame_out !== frame) begin
         n_err++;
         $display("FAIL %s: got fv=%0b ov=%0b cnt=%0d frame=%h, expected fv=%0b ov=%0b cnt=%0d frame=%h",
                  name, frame_valid, overrun, overrun_count, frame_out, fv, ov, cnt, frame);
      end
   endtask

   task automatic apply(input int i);
      reset        = vecs[i].rst;
      sample_valid = vecs[i].sv;
      sample_in    = vecs[i].smp;
      proc_done    = vecs[i].pd;
      tick();
      check($sformatf("vec%0d", i), vecs[i].fv, vecs[i].ov, vecs[i].cnt, vecs[i].frame);
   endtask

   initial begin
      // rst sv smp pd | fv ov cnt frame
      add(1, 0,  0, 0,  0, 0,   0, F0);   // 0 reset
      add(0, 1,  1, 0,  0, 0,   0, F0);
      add(0, 1, -2, 0,  0, 0,   0, F0);
      add(0, 1,  3, 0,  0, 0,   0, F0);
      add(0, 1, -4, 0,  1, 0,   0, F1);   // 4 first frame published
      add(0, 1,  5, 0,  1, 0,   0, F1);
      add(0, 1,  6, 0,  1, 0,   0, F1);
      add(0, 1,  7, 0,  1, 0,   0, F1);
      add(0, 1,  8, 0,  1, 0,   0, F1);   // 8 both banks full
      add(0, 1,  9, 0,  1, 1,   1, F1);   // 9 dropped
      add(0, 0,  0, 0,  1, 0,   1, F1);
      add(0, 0,  0, 1,  1, 0,   1, F2);   // 11 release from stall
      add(0, 1, 10, 0,  1, 0,   1, F2);
      add(0, 1, 11, 0,  1, 0,   1, F2);
      add(0, 1, 12, 0,  1, 0,   1, F2);
      add(0, 1, 13, 1,  1, 0,   1, F3);   // 15 completion with proc_done
      add(0, 0,  0, 0,  1, 0,   1, F3);
      add(0, 1, 20, 0,  1, 0,   1, F3);
      add(0, 1, 21, 0,  1, 0,   1, F3);
      add(0, 1, 22, 0,  1, 0,   1, F3);
      add(0, 1, 23, 0,  1, 0,   1, F3);   // 20 stalled again
      add(0, 0,  0, 0,  1, 0, 255, F3);   // 21
      add(0, 1, 99, 1,  1, 1, 255, F4);   // 22 drop and swap together
      add(0, 0,  0, 0,  1, 0, 255, F4);
      add(0, 0,  0, 1,  0, 0, 255, F4);   // 24 release to FILL
      add(0, 1, 30, 0,  0, 0, 255, F4);
      add(0, 1, 31, 0,  0, 0, 255, F4);
      add(1, 1, 77, 0,  0, 0,   0, F0);   // 27 reset mid-frame
      add(0, 0,  0, 1,  0, 0,   0, F0);   // proc_done ignored
      add(0, 1, 40, 0,  0, 0,   0, F0);
      add(0, 1, 41, 0,  0, 0,   0, F0);
      add(0, 1, 42, 0,  0, 0,   0, F0);
      add(0, 1, 43, 0,  1, 0,   0, F5);   // 32

      for (int i = 0; i < 21; i++) apply(i);

      // 300 dropped samples in STALL: counter must stick at all-ones.
      for (int i = 0; i < 300; i++) begin
         sample_valid = 1'b1;
         sample_in    = SS'(1000 + i);
         proc_done    = 1'b0;
         tick();
         if (i == 99)  check("sat_mid", 1'b1, 1'b1, CW'(101), F3);
         if (i == 253) check("sat_reach", 1'b1, 1'b1, CW'(255), F3);
      end
      check("sat_end", 1'b1, 1'b1, CW'(255), F3);

      for (int i = 21; i < vecs.size(); i++) apply(i);

      sample_valid = 1'b0;
      proc_done    = 1'b0;
      tick();
      check("hold_after", 1'b1, 1'b0, CW'(0), F5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
